// File: rtl/stoch_signed_decode_mat.sv
// Decodes a matrix of signed p/m stochastic bitstreams into per-element window sums.
// Result is registered one cycle after the final sample; a full Y that is not consumed drops the new window and sets overrun.
module stoch_signed_decode_mat #(
   parameter int NUM_ROWS = 2,
   parameter int NUM_COLS = 2,
   parameter int WIN_BITS = 8
) (
   input  logic                                       CLK,
   input  logic                                       RST,
   input  logic                                       start,
   input  logic                                       en,
   input  logic [NUM_ROWS*NUM_COLS-1:0]               A_p,
   input  logic [NUM_ROWS*NUM_COLS-1:0]               A_m,
   output logic [NUM_ROWS*NUM_COLS*(WIN_BITS+2)-1:0]  Y,
   output logic                                       Y_valid,
   input  logic                                       Y_ready,
   output logic                                       busy,
   output logic                                       overrun
);

   localparam int W = WIN_BITS + 2;
   localparam int N = NUM_ROWS * NUM_COLS;

   typedef enum logic {IDLE, RUN} state_t;

   state_t              state;
   state_t              state_next;
   logic [WIN_BITS-1:0] cnt;
   logic signed [W-1:0] acc      [N];
   logic signed [W-1:0] acc_next [N];
   logic signed [W-1:0] y_reg    [N];
   logic                sample;
   logic                last;
   logic                launch;
   logic                load;

   always_comb begin
      sample = (state == RUN) && en;
      last   = sample && (cnt == '1);
      launch = (state == IDLE) && start;
      // A completing window only lands in Y if the previous result is gone or leaving now.
      load   = last && (!Y_valid || Y_ready);
      busy   = (state == RUN);
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start) state_next = RUN;
         RUN:  if (last)  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      for (int k = 0; k < N; k++) begin
         case ({A_p[k], A_m[k]})
            2'b10:   acc_next[k] = acc[k] + W'(1);
            2'b01:   acc_next[k] = acc[k] - W'(1);
            default: acc_next[k] = acc[k];
         endcase
      end
   end

   // The counter wraps to zero on the final sample, so no explicit clear is needed at completion.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt <= '0;
         for (int k = 0; k < N; k++) acc[k] <= '0;
      end else if (launch) begin
         cnt <= '0;
         for (int k = 0; k < N; k++) acc[k] <= '0;
      end else if (sample) begin
         cnt <= cnt + WIN_BITS'(1);
         for (int k = 0; k < N; k++) acc[k] <= acc_next[k];
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int k = 0; k < N; k++) y_reg[k] <= '0;
         Y_valid <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (load) begin
            for (int k = 0; k < N; k++) y_reg[k] <= acc_next[k];
            Y_valid <= 1'b1;
         end else if (Y_valid && Y_ready) begin
            Y_valid <= 1'b0;
         end
         if (launch)            overrun <= 1'b0;
         else if (last && !load) overrun <= 1'b1;
      end
   end

   always_comb begin
      Y = '0;
      for (int k = 0; k < N; k++) Y[k*W +: W] = y_reg[k];
   end

endmodule

// File: tb/tb_stoch_signed_decode_mat.sv
// Bench for stoch_signed_decode_mat (2x2, WIN_BITS=4): directed cases then random traffic against an integer model.
module tb_stoch_signed_decode_mat;

   localparam int WB  = 4;
   localparam int W   = WB + 2;
   localparam int N   = 4;
   localparam int WIN = 1 << WB;

   logic           CLK;
   logic           RST;
   logic           start;
   logic           en;
   logic [N-1:0]   A_p;
   logic [N-1:0]   A_m;
   logic [N*W-1:0] Y;
   logic           Y_valid;
   logic           Y_ready;
   logic           busy;
   logic           overrun;

   int total;
   int bad;

   // Reference model: plain integer sums and flags following the behavioural rules.
   bit m_busy;
   bit m_yv;
   bit m_ovr;
   int m_cnt;
   int m_acc [N];
   int m_y   [N];

   stoch_signed_decode_mat #(
      .NUM_ROWS(2),
      .NUM_COLS(2),
      .WIN_BITS(WB)
   ) dut (
      .CLK     (CLK),
      .RST     (RST),
      .start   (start),
      .en      (en),
      .A_p     (A_p),
      .A_m     (A_m),
      .Y       (Y),
      .Y_valid (Y_valid),
      .Y_ready (Y_ready),
      .busy    (busy),
      .overrun (overrun)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   function automatic logic [31:0] y_el(input int k);
      return 32'($signed(Y[k*W +: W]));
   endfunction

   task automatic model_reset();
      m_busy = 0;
      m_yv   = 0;
      m_ovr  = 0;
      m_cnt  = 0;
      for (int k = 0; k < N; k++) begin
         m_acc[k] = 0;
         m_y[k]   = 0;
      end
   endtask

   task automatic check_all();
      chk("busy", 32'(busy), 32'(m_busy));
      chk("y_valid", 32'(Y_valid), 32'(m_yv));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      for (int k = 0; k < N; k++) chk($sformatf("y%0d", k), y_el(k), 32'(m_y[k]));
   endtask

   // Advance the model with the inputs presented this cycle, clock the DUT, then compare.
   task automatic cycle();
      bit done;
      done = 0;
      if (!m_busy) begin
         if (start) begin
            m_busy = 1;
            m_cnt  = 0;
            m_ovr  = 0;
            for (int k = 0; k < N; k++) m_acc[k] = 0;
         end
      end else if (en) begin
         for (int k = 0; k < N; k++) m_acc[k] += int'(A_p[k]) - int'(A_m[k]);
         m_cnt++;
         if (m_cnt == WIN) begin
            m_busy = 0;
            done   = 1;
            if (!m_yv || Y_ready) begin
               m_y  = m_acc;
               m_yv = 1;
            end else begin
               m_ovr = 1;
            end
         end
      end
      if (!done && m_yv && Y_ready) m_yv = 0;
      @(posedge CLK);
      #1;
      check_all();
   endtask

   task automatic drive(input bit s, input bit e, input logic [N-1:0] p,
                        input logic [N-1:0] m, input bit r);
      start   = s;
      en      = e;
      A_p     = p;
      A_m     = m;
      Y_ready = r;
      cycle();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      model_reset();
      RST     = 1'b1;
      start   = 1'b0;
      en      = 1'b0;
      A_p     = '0;
      A_m     = '0;
      Y_ready = 1'b1;
      #12;
      check_all();
      RST = 1'b0;
      @(posedge CLK);
      #1;

      // Case 1: all +1 for a full window.
      drive(1, 1, 4'hF, 4'h0, 1);
      chk("c1_busy_after_start", 32'(busy), 32'd1);
      for (int s = 0; s < WIN; s++) drive(0, 1, 4'hF, 4'h0, 1);
      chk("c1_busy_end", 32'(busy), 32'd0);
      chk("c1_valid", 32'(Y_valid), 32'd1);
      for (int k = 0; k < N; k++) chk($sformatf("c1_y%0d", k), y_el(k), 32'd16);

      // Case 2: cancel, alternating, all-minus, all-zero.
      drive(1, 0, 4'h0, 4'h0, 1);
      for (int s = 0; s < WIN; s++) drive(0, 1, {2'b00, (s % 2 == 0), 1'b1}, 4'b0101, 1);
      chk("c2_y0", y_el(0), 32'd0);
      chk("c2_y1", y_el(1), 32'd8);
      chk("c2_y2", y_el(2), -32'sd16);
      chk("c2_y3", y_el(3), 32'd0);

      // Case 3: en toggling stretches the window to 32 cycles.
      drive(1, 0, 4'hF, 4'h0, 1);
      for (int c = 0; c < 2 * WIN; c++) begin
         if (c == 2 * WIN - 1) chk("c3_busy_before_last", 32'(busy), 32'd1);
         drive(0, (c % 2 == 1), 4'hF, 4'h0, 1);
      end
      chk("c3_busy_end", 32'(busy), 32'd0);
      for (int k = 0; k < N; k++) chk($sformatf("c3_y%0d", k), y_el(k), 32'd16);

      // Case 4: consumer stalled across two windows.
      drive(0, 0, 4'h0, 4'h0, 1);
      drive(1, 0, 4'h0, 4'h0, 0);
      for (int s = 0; s < WIN; s++) drive(0, 1, 4'hF, 4'h0, 0);
      drive(1, 0, 4'h0, 4'h0, 0);
      for (int s = 0; s < WIN; s++) drive(0, 1, 4'h0, 4'hF, 0);
      chk("c4_overrun", 32'(overrun), 32'd1);
      chk("c4_valid_held", 32'(Y_valid), 32'd1);
      for (int k = 0; k < N; k++) chk($sformatf("c4_y%0d", k), y_el(k), 32'd16);
      drive(0, 0, 4'h0, 4'h0, 1);
      chk("c4_consumed", 32'(Y_valid), 32'd0);
      drive(1, 1, 4'hF, 4'h0, 1);
      chk("c4_overrun_cleared", 32'(overrun), 32'd0);

      // Case 5: reset after 7 samples.
      for (int s = 0; s < 7; s++) drive(0, 1, 4'hF, 4'h0, 1);
      RST = 1'b1;
      start = 1'b0;
      #2;
      model_reset();
      chk("c5_rst_busy", 32'(busy), 32'd0);
      chk("c5_rst_valid", 32'(Y_valid), 32'd0);
      for (int k = 0; k < N; k++) chk($sformatf("c5_rst_y%0d", k), y_el(k), 32'd0);
      @(negedge CLK);
      RST = 1'b0;
      @(posedge CLK);
      #1;
      drive(1, 0, 4'h0, 4'h0, 1);
      for (int s = 0; s < WIN; s++) begin
         if (s == WIN - 1) chk("c5_busy_15", 32'(busy), 32'd1);
         drive(0, 1, 4'h0, 4'hF, 1);
      end
      for (int k = 0; k < N; k++) chk($sformatf("c5_y%0d", k), y_el(k), -32'sd16);

      // Case 6: completion coincides with a consume; start held high throughout.
      drive(1, 0, 4'h0, 4'h0, 0);
      for (int s = 0; s < WIN; s++) drive(1, 1, 4'b0001, 4'h0, (s == WIN - 1));
      chk("c6_busy", 32'(busy), 32'd0);
      chk("c6_valid", 32'(Y_valid), 32'd1);
      chk("c6_overrun", 32'(overrun), 32'd0);
      chk("c6_y0", y_el(0), 32'd16);
      chk("c6_y1", y_el(1), 32'd0);
      drive(0, 0, 4'h0, 4'h0, 1);
      chk("c6_consumed", 32'(Y_valid), 32'd0);

      // Random traffic.
      for (int c = 0; c < 3000; c++) begin
         drive(($urandom % 8) == 0, ($urandom % 4) != 0, 4'($urandom), 4'($urandom),
               ($urandom % 3) != 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
